// File: rtl/regfile_multiport.sv
// Multiport register bank: N_RD registered read ports, one write port, one debug read port,
// a post-reset clear sequence and a ready flag. Optional macro REGFILE_BYPASS_EN selects write-first reads.
module regfile_multiport #(
  parameter int unsigned NB_REG     = 5,
  parameter int unsigned NB_DATA    = 32,
  parameter int unsigned N_REGISTER = 32,
  parameter int unsigned N_RD       = 2
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      wr_en_i,
  input  logic [NB_REG-1:0]         wr_addr_i,
  input  logic [NB_DATA-1:0]        wr_data_i,
  input  logic [N_RD*NB_REG-1:0]    rd_addr_i,
  output logic [N_RD*NB_DATA-1:0]   rd_data_o,
  input  logic [NB_REG-1:0]         dbg_addr_i,
  output logic [NB_DATA-1:0]        dbg_data_o,
  output logic                      ready_o,
  output logic                      wr_drop_o
);

  localparam int unsigned LAST_IDX = N_REGISTER - 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [NB_REG-1:0]         r_clr_idx;
  logic [NB_REG-1:0]         w_next_clr_idx;
  logic                      w_clr_last;
  logic                      w_wr_accept;
  logic [NB_DATA-1:0]        r_regs [N_REGISTER];
  logic [N_RD*NB_DATA-1:0]   r_rd_data;
  logic [N_RD*NB_DATA-1:0]   w_rd_next;
  logic [NB_DATA-1:0]        r_dbg_data;
  logic [NB_DATA-1:0]        w_dbg_next;
  logic                      r_ready;
  logic                      r_wr_drop;

  // Address maps to an implemented, non-zero register
  function automatic logic f_addr_ok(input logic [NB_REG-1:0] a);
    return (a != '0) && (32'(a) < N_REGISTER);
  endfunction

  // Clear sequencer next-state
  always_comb begin
    w_next_state   = r_state;
    w_next_clr_idx = r_clr_idx;
    w_clr_last     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_last     = (r_clr_idx == NB_REG'(LAST_IDX));
        w_next_clr_idx = w_clr_last ? '0 : r_clr_idx + NB_REG'(1);
        if (w_clr_last) begin
          w_next_state = ST_READY;
        end
      end
      ST_READY: begin
        w_next_state = ST_READY;
      end
      default: begin
        w_next_state = ST_CLEAR;
      end
    endcase
  end

  assign w_wr_accept = (r_state == ST_READY) && wr_en_i && f_addr_ok(wr_addr_i);

  // Read mux; everything reads zero until the clear sequence finishes
  always_comb begin
    logic [NB_REG-1:0] v_addr;
    w_rd_next  = '0;
    w_dbg_next = '0;
    v_addr     = '0;
    if (r_state == ST_READY) begin
      for (int unsigned k = 0; k < N_RD; k++) begin
        v_addr = rd_addr_i[k*NB_REG +: NB_REG];
        if (f_addr_ok(v_addr)) begin
          w_rd_next[k*NB_DATA +: NB_DATA] = r_regs[v_addr];
        end
`ifdef REGFILE_BYPASS_EN
        if (w_wr_accept && (v_addr == wr_addr_i)) begin
          w_rd_next[k*NB_DATA +: NB_DATA] = wr_data_i;
        end
`endif
      end
      if (f_addr_ok(dbg_addr_i)) begin
        w_dbg_next = r_regs[dbg_addr_i];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state    <= ST_CLEAR;
      r_clr_idx  <= '0;
      r_rd_data  <= '0;
      r_dbg_data <= '0;
      r_ready    <= 1'b0;
      r_wr_drop  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_clr_idx  <= w_next_clr_idx;
      r_rd_data  <= w_rd_next;
      r_dbg_data <= w_dbg_next;
      r_ready    <= (w_next_state == ST_READY);
      r_wr_drop  <= (r_state == ST_CLEAR) && wr_en_i;
    end
  end

  // Storage array has no reset; the clear sequence zeroes it one entry per cycle
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      if (r_state == ST_CLEAR) begin
        r_regs[r_clr_idx] <= '0;
      end else if (w_wr_accept) begin
        r_regs[wr_addr_i] <= wr_data_i;
      end
    end
  end

  assign rd_data_o  = r_rd_data;
  assign dbg_data_o = r_dbg_data;
  assign ready_o    = r_ready;
  assign wr_drop_o  = r_wr_drop;

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the MIPS register bank. Provides N_RD synchronous read ports, one write port and one debug read port for the debug unit.
- Adds a sequential clear engine that zeroes every register after reset, a ready flag, and compile-time write-to-read forwarding.
- Sits in the ID stage. Write port is driven from WB.

Parameters:
- NB_REG, 5, address width
- NB_DATA, 32, data width
- N_REGISTER, 32, implemented registers (1..2^NB_REG); index 0 hardwired to zero
- N_RD, 2, number of read ports (1..4)

Ports:
- clock_i  in  1  system clock; all state changes on rising edge
- reset_i  in  1  synchronous, active-high reset
- wr_en_i  in  1  write request
- wr_addr_i  in  NB_REG  write address
- wr_data_i  in  NB_DATA  write data
- rd_addr_i  in  N_RD*NB_REG  packed read addresses; port k at bits [k*NB_REG +: NB_REG]
- rd_data_o  out  N_RD*NB_DATA  packed registered read data; port k at [k*NB_DATA +: NB_DATA]
- dbg_addr_i  in  NB_REG  debug read address
- dbg_data_o  out  NB_DATA  registered debug read data
- ready_o  out  1  high once clear sequence is complete
- wr_drop_o  out  1  one-cycle pulse: a write request was discarded

Behaviour:
- Reset (reset_i=1 at an edge):
  - state<=CLEAR, clr_idx<=0.
  - rd_data_o, dbg_data_o, ready_o and wr_drop_o <= 0.
  - Reset held high keeps the block in this condition; the array is not written while reset is high.
- FSM has two states, CLEAR and READY.
- CLEAR:
  - Each cycle, registers[clr_idx]<=0 and clr_idx increments.
  - At the edge where clr_idx==N_REGISTER-1 is written, state<=READY and ready_o<=1.
  - Clear takes exactly N_REGISTER cycles after reset deasserts.
  - Reset asserted mid-clear restarts at index 0.
- During CLEAR:
  - All read outputs register 0.
  - wr_en_i=1 is discarded and wr_drop_o pulses 1 on the following cycle.
- READY, write:
  - If wr_en_i=1 and 0<wr_addr_i<N_REGISTER, registers[wr_addr_i]<=wr_data_i.
  - Writes to address 0 or to an address >=N_REGISTER are ignored silently (no drop pulse).
- READY, read:
  - Every cycle, each port k registers registers[rd_addr k]; latency is 1 cycle.
  - Address 0 or >=N_REGISTER reads 0.
  - Ports are independent; any ports may use the same address.
- Debug read:
  - dbg_data_o follows the same rules, 1-cycle latency.
  - Never forwarded: returns the pre-write value on a same-cycle write.
- Read-during-write to the same nonzero address: the result is governed by the optional feature below.
- ready_o stays 1 until the next reset.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-first.
  - Any read port whose address equals wr_addr_i at an edge where a READY write is accepted registers wr_data_i in that same cycle.
  - Address 0 is never forwarded.
  - The debug port is excluded.
- Undefined: read-first. The port registers the old contents; the new value is visible one cycle later.

Test Plan:
- Clear timing, N_REGISTER=32: hold reset 3 cycles then release -> ready_o=0 for exactly 32 cycles, rises on the 32nd edge; afterwards reading every address 0..31 returns 0.
- Write/read, N_RD=2: write 0xDEADBEEF to r5 and 0x12345678 to r31 -> next cycles with rd_addr={5,31} give rd_data port0=0xDEADBEEF and port1=0x12345678, one cycle after the address is applied.
- Zero register: write 0xFFFFFFFF to r0 -> all ports and debug read 0 at address 0; wr_drop_o stays 0.
- Bypass: r7=0x11 already written, then same-cycle write 0x22 to r7 with rd_addr port0=7.
  - REGFILE_BYPASS_EN defined -> port0=0x22 next cycle.
  - Undefined -> 0x11, then 0x22 one cycle later.
  - Debug port at address 7 gives 0x11 in both builds.
- Write during clear: wr_en_i=1 with r3 <- 0xAA at clear cycle 4 -> wr_drop_o=1 for one cycle; r3 reads 0 after ready.
- Reset mid-clear: assert reset at clear cycle 10 for 1 cycle -> ready_o rises exactly 32 cycles after release.
